// File: rtl/rob_pkg.sv
// Shared ROB recovery types and sizing constants.
package rob_pkg;

    localparam int ROB_DEPTH = 128;
    localparam int ROB_IDX_W = 7;
    localparam int ARCH_W    = 5;
    localparam int PHYS_W    = 8;

    typedef logic [ROB_IDX_W-1:0] rob_idx_t;
    typedef logic [ARCH_W-1:0]    arch_reg_t;
    typedef logic [PHYS_W-1:0]    phys_reg_t;

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        WALK,
        REDIRECT
    } recov_state_e;

endpackage

// File: rtl/rob_walk_lanes.sv
// Combinational lane generator for the squash walk: youngest-first ROB
// indices below the cursor, the valid mask and the number of active lanes.
module rob_walk_lanes #(
    parameter int IDX_W  = 7,
    parameter int WALK_W = 4
) (
    input  logic                    en_i,
    input  logic [IDX_W-1:0]        cursor_i,
    input  logic [IDX_W:0]          remaining_i,
    output logic [WALK_W*IDX_W-1:0] idx_o,
    output logic [WALK_W-1:0]       valid_o,
    output logic [IDX_W:0]          count_o
);
    import rob_pkg::*;

    localparam logic [IDX_W:0] LANES = (IDX_W+1)'(WALK_W);

    assign count_o = !en_i ? '0 : ((remaining_i > LANES) ? LANES : remaining_i);

    // Indices wrap naturally in IDX_W bits since DEPTH is a power of two.
    for (genvar gi = 0; gi < WALK_W; gi++) begin : g_lane
        assign valid_o[gi] = ((IDX_W+1)'(gi) < count_o);
        assign idx_o[gi*IDX_W +: IDX_W] = valid_o[gi] ? (cursor_i - IDX_W'(gi)) : '0;
    end

endmodule

// File: rtl/rob_recovery_ctrl.sv
// ROB rollback sequencer: drain, youngest-first rename walk, tail rewind and redirect.
// Optional statistics counters are enabled by defining ROB_RECOVERY_STATS_EN.
module rob_recovery_ctrl #(
    parameter int DEPTH  = 128,
    parameter int IDX_W  = 7,
    parameter int WALK_W = 4,
    parameter int ARCH_W = 5,
    parameter int PHYS_W = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     exc_valid,
    input  logic [IDX_W-1:0]         exc_index,
    input  logic [IDX_W-1:0]         rob_tail,
    output logic [WALK_W*IDX_W-1:0]  rd_index,
    input  logic [WALK_W*ARCH_W-1:0] rd_arch,
    input  logic [WALK_W*PHYS_W-1:0] rd_phys,
    output logic [WALK_W-1:0]        restore_valid,
    output logic [WALK_W*ARCH_W-1:0] restore_arch,
    output logic [WALK_W*PHYS_W-1:0] restore_phys,
    output logic                     dispatch_stall,
    output logic                     tail_set_valid,
    output logic [IDX_W-1:0]         tail_set_value,
    output logic                     redirect,
    output logic                     busy
`ifdef ROB_RECOVERY_STATS_EN
    ,
    output logic [15:0]              recovery_count,
    output logic [23:0]              squash_total
`endif
);
    import rob_pkg::*;

    localparam logic [IDX_W:0] IDX_MASK = (IDX_W+1)'(DEPTH - 1);

    recov_state_e     state_q, state_d;
    logic [IDX_W-1:0] exc_idx_q, exc_idx_d;
    logic [IDX_W-1:0] cursor_q, cursor_d;
    logic [IDX_W:0]   remaining_q, remaining_d;
    logic [IDX_W:0]   lane_count;
    logic [IDX_W-1:0] tail_diff;
    logic             walk_en;

    assign walk_en   = (state_q == WALK);
    assign tail_diff = rob_tail - exc_idx_q;

    rob_walk_lanes #(
        .IDX_W  (IDX_W),
        .WALK_W (WALK_W)
    ) u_lanes (
        .en_i        (walk_en),
        .cursor_i    (cursor_q),
        .remaining_i (remaining_q),
        .idx_o       (rd_index),
        .valid_o     (restore_valid),
        .count_o     (lane_count)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            exc_idx_q   <= '0;
            cursor_q    <= '0;
            remaining_q <= '0;
        end else begin
            state_q     <= state_d;
            exc_idx_q   <= exc_idx_d;
            cursor_q    <= cursor_d;
            remaining_q <= remaining_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        exc_idx_d   = exc_idx_q;
        cursor_d    = cursor_q;
        remaining_d = remaining_q;
        case (state_q)
            IDLE: begin
                // Tail is sampled one cycle later so same-cycle inserts are counted.
                if (exc_valid) begin
                    exc_idx_d = exc_index;
                    state_d   = DRAIN;
                end
            end
            DRAIN: begin
                cursor_d    = rob_tail - IDX_W'(1);
                remaining_d = {1'b0, tail_diff} & IDX_MASK;
                state_d     = (tail_diff == '0) ? REDIRECT : WALK;
            end
            WALK: begin
                cursor_d    = cursor_q - lane_count[IDX_W-1:0];
                remaining_d = remaining_q - lane_count;
                if (remaining_q == lane_count) begin
                    state_d = REDIRECT;
                end
            end
            REDIRECT: state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        busy           = (state_q != IDLE);
        dispatch_stall = busy;
        tail_set_valid = (state_q == REDIRECT);
        redirect       = tail_set_valid;
        tail_set_value = tail_set_valid ? exc_idx_q : '0;
    end

    for (genvar gi = 0; gi < WALK_W; gi++) begin : g_restore
        assign restore_arch[gi*ARCH_W +: ARCH_W] =
            restore_valid[gi] ? rd_arch[gi*ARCH_W +: ARCH_W] : '0;
        assign restore_phys[gi*PHYS_W +: PHYS_W] =
            restore_valid[gi] ? rd_phys[gi*PHYS_W +: PHYS_W] : '0;
    end

`ifdef ROB_RECOVERY_STATS_EN
    logic [15:0] recovery_count_q;
    logic [23:0] squash_total_q;
    logic [24:0] squash_sum;

    assign squash_sum = {1'b0, squash_total_q} + 25'($countones(restore_valid));

    always_ff @(posedge clk) begin
        if (!reset) begin
            recovery_count_q <= '0;
            squash_total_q   <= '0;
        end else begin
            if (tail_set_valid && (recovery_count_q != '1)) begin
                recovery_count_q <= recovery_count_q + 16'd1;
            end
            squash_total_q <= squash_sum[24] ? '1 : squash_sum[23:0];
        end
    end

    assign recovery_count = recovery_count_q;
    assign squash_total   = squash_total_q;
`endif

endmodule

// File: tb/tb_rob_recovery_ctrl.sv
// Directed bench for rob_recovery_ctrl with a combinational ROB read model.
module tb_rob_recovery_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        exc_valid;
    logic [6:0]  exc_index;
    logic [6:0]  rob_tail;
    logic [27:0] rd_index;
    logic [19:0] rd_arch;
    logic [31:0] rd_phys;
    logic [3:0]  restore_valid;
    logic [19:0] restore_arch;
    logic [31:0] restore_phys;
    logic        dispatch_stall;
    logic        tail_set_valid;
    logic [6:0]  tail_set_value;
    logic        redirect;
    logic        busy;
`ifdef ROB_RECOVERY_STATS_EN
    logic [15:0] recovery_count;
    logic [23:0] squash_total;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rob_recovery_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .exc_valid      (exc_valid),
        .exc_index      (exc_index),
        .rob_tail       (rob_tail),
        .rd_index       (rd_index),
        .rd_arch        (rd_arch),
        .rd_phys        (rd_phys),
        .restore_valid  (restore_valid),
        .restore_arch   (restore_arch),
        .restore_phys   (restore_phys),
        .dispatch_stall (dispatch_stall),
        .tail_set_valid (tail_set_valid),
        .tail_set_value (tail_set_value),
        .redirect       (redirect),
        .busy           (busy)
`ifdef ROB_RECOVERY_STATS_EN
        ,
        .recovery_count (recovery_count),
        .squash_total   (squash_total)
`endif
    );

    // ROB contents: arch = low 5 index bits, phys = {1, index}.
    always_comb begin
        rd_arch = '0;
        rd_phys = '0;
        for (int k = 0; k < 4; k++) begin
            rd_arch[k*5 +: 5] = rd_index[k*7 +: 5];
            rd_phys[k*8 +: 8] = {1'b1, rd_index[k*7 +: 7]};
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".ctl"}, {busy, dispatch_stall, redirect, tail_set_valid, restore_valid}, 64'd0);
        check({tag, ".idx"}, rd_index, 64'd0);
        check({tag, ".rst"}, {restore_arch, restore_phys, tail_set_value}, 64'd0);
    endtask

    task automatic check_drain(input string tag);
        check({tag, ".ctl"}, {busy, dispatch_stall, redirect, tail_set_valid, restore_valid}, 64'b11_0_0_0000);
    endtask

    task automatic check_walk(input string tag, input logic [27:0] idx, input logic [3:0] mask,
                              input logic [19:0] arch, input logic [31:0] phys);
        check({tag, ".ctl"}, {busy, dispatch_stall, redirect, tail_set_valid}, 64'b1100);
        check({tag, ".idx"}, rd_index, idx);
        check({tag, ".mask"}, restore_valid, mask);
        check({tag, ".arch"}, restore_arch, arch);
        check({tag, ".phys"}, restore_phys, phys);
    endtask

    task automatic check_redirect(input string tag, input logic [6:0] val);
        check({tag, ".ctl"}, {busy, dispatch_stall, redirect, tail_set_valid, restore_valid}, 64'b1111_0000);
        check({tag, ".val"}, tail_set_value, val);
    endtask

    task automatic raise_exc(input logic [6:0] idx, input logic [6:0] tail);
        exc_index = idx;
        rob_tail  = tail;
        exc_valid = 1'b1;
        tick();
        exc_valid = 1'b0;
    endtask

    initial begin
        reset     = 1'b0;
        exc_valid = 1'b0;
        exc_index = '0;
        rob_tail  = '0;
        tick();
        tick();
        check_idle("reset");
        reset = 1'b1;
        tick();
        check_idle("post_reset");

        // 10-entry recovery: exc 5, tail 15
        raise_exc(7'd5, 7'd15);
        check_drain("a.drain");
        tick();
        check_walk("a.w1", {7'd11, 7'd12, 7'd13, 7'd14}, 4'b1111,
                   {5'd11, 5'd12, 5'd13, 5'd14}, {8'd139, 8'd140, 8'd141, 8'd142});
        tick();
        check_walk("a.w2", {7'd7, 7'd8, 7'd9, 7'd10}, 4'b1111,
                   {5'd7, 5'd8, 5'd9, 5'd10}, {8'd135, 8'd136, 8'd137, 8'd138});
        tick();
        check_walk("a.w3", {7'd0, 7'd0, 7'd5, 7'd6}, 4'b0011,
                   {5'd0, 5'd0, 5'd5, 5'd6}, {8'd0, 8'd0, 8'd133, 8'd134});
        tick();
        check_redirect("a.redir", 7'd5);
        tick();
        check_idle("a.done");

        // Wrapping 4-entry recovery: exc 126, tail 2
        raise_exc(7'd126, 7'd2);
        check_drain("b.drain");
        tick();
        check_walk("b.w1", {7'd126, 7'd127, 7'd0, 7'd1}, 4'b1111,
                   {5'd30, 5'd31, 5'd0, 5'd1}, {8'd254, 8'd255, 8'd128, 8'd129});
        tick();
        check_redirect("b.redir", 7'd126);
        tick();
        check_idle("b.done");
`ifdef ROB_RECOVERY_STATS_EN
        check("stats.recoveries", recovery_count, 64'd2);
        check("stats.squashed", squash_total, 64'd14);
`endif

        // Empty range: stall for DRAIN + REDIRECT only
        raise_exc(7'd40, 7'd40);
        check_drain("c.drain");
        tick();
        check_redirect("c.redir", 7'd40);
        tick();
        check_idle("c.done");

        // Second exception during WALK is ignored
        raise_exc(7'd5, 7'd15);
        tick();
        check_walk("d.w1", {7'd11, 7'd12, 7'd13, 7'd14}, 4'b1111,
                   {5'd11, 5'd12, 5'd13, 5'd14}, {8'd139, 8'd140, 8'd141, 8'd142});
        raise_exc(7'd9, 7'd15);
        check_walk("d.w2", {7'd7, 7'd8, 7'd9, 7'd10}, 4'b1111,
                   {5'd7, 5'd8, 5'd9, 5'd10}, {8'd135, 8'd136, 8'd137, 8'd138});
        tick();
        check_walk("d.w3", {7'd0, 7'd0, 7'd5, 7'd6}, 4'b0011,
                   {5'd0, 5'd0, 5'd5, 5'd6}, {8'd0, 8'd0, 8'd133, 8'd134});
        tick();
        check_redirect("d.redir", 7'd5);
        tick();
        check_idle("d.done");
        tick();
        check_idle("d.stay_idle");

        // Reset asserted mid-walk aborts the recovery
        raise_exc(7'd5, 7'd15);
        tick();
        check("e.walking", restore_valid, 64'b1111);
        reset = 1'b0;
        tick();
        check_idle("e.rst1");
        tick();
        check_idle("e.rst2");
        reset = 1'b1;
        tick();
        check_idle("e.rel1");
        tick();
        check_idle("e.rel2");
`ifdef ROB_RECOVERY_STATS_EN
        check("e.stats_clr", {recovery_count, squash_total}, 64'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
